// File: rtl/multibank_palette_lut.sv
// Multi-bank runtime-writable colour palette.
// The lookup index and bank select address one palette RAM. The result is faded
// and the transparency key is applied. The result appears two edges after the
// request is sampled. After reset an INIT sequence clears every entry, one entry
// per cycle. During INIT the write port is closed and lookups are dropped.
//
// Write handshake: a write transfers on a rising edge where wr_valid and
// wr_ready are both high. wr_ready is high in IDLE and low in INIT. No other
// backpressure exists. A write whose bank is >= NUM_BANKS still completes the
// handshake, but its data is discarded.
module multibank_palette_lut #(
    parameter int INDEX_W   = 8,
    parameter int NUM_BANKS = 2,
    parameter int COLOR_W   = 4,
    parameter int TRANS_IDX = 0,
    localparam int BANK_W   = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
    input  logic                   Clk,
    input  logic                   Reset_n,
    input  logic                   pix_valid,
    input  logic [BANK_W-1:0]      pix_bank,
    input  logic [INDEX_W-1:0]     pix_index,
    input  logic [1:0]             fade,
    input  logic                   trans_en,
    input  logic                   wr_valid,
    output logic                   wr_ready,
    input  logic [BANK_W-1:0]      wr_bank,
    input  logic [INDEX_W-1:0]     wr_addr,
    input  logic [3*COLOR_W-1:0]   wr_data,
    output logic                   pix_valid_out,
    output logic [COLOR_W-1:0]     red,
    output logic [COLOR_W-1:0]     green,
    output logic [COLOR_W-1:0]     blue,
    output logic                   transparent_out,
    output logic                   init_busy
);

    localparam int DEPTH  = 2 ** INDEX_W;
    localparam int TOTAL  = NUM_BANKS * DEPTH;
    localparam int ADDR_W = BANK_W + INDEX_W;
    localparam int DATA_W = 3 * COLOR_W;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_IDLE = 1'b1
    } state_t;

    // FSM and clear counter
    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_clr_cnt;
    logic                w_clr_last;
    logic                w_clr_we;
    logic                w_init_busy;
    logic                w_wr_ready;

    // Write/read addressing
    logic                w_wr_bank_ok;
    logic                w_pix_bank_ok;
    logic                w_usr_we;
    logic [ADDR_W-1:0]   w_wr_addr;
    logic [ADDR_W-1:0]   w_rd_addr;
    logic                w_mem_we;
    logic [ADDR_W-1:0]   w_mem_addr;
    logic [DATA_W-1:0]   w_mem_wdata;
    logic                w_lookup;
    logic                w_byp_hit;

    // Palette storage and the registered read port
    logic [DATA_W-1:0]   r_mem [0:TOTAL-1];
    logic [DATA_W-1:0]   r_rd_raw;

    // Stage 1: request captured together with the RAM read
    logic                r_s1_valid;
    logic                r_s1_bank_ok;
    logic                r_s1_trans;
    logic [1:0]          r_s1_fade;
    logic                r_s1_byp_hit;
    logic [DATA_W-1:0]   r_s1_byp_data;
    logic [DATA_W-1:0]   w_s1_entry;

    // Stage 2: resolved entry, waiting for fade and key
    logic                r_s2_valid;
    logic                r_s2_trans;
    logic [1:0]          r_s2_fade;
    logic [DATA_W-1:0]   r_s2_entry;
    logic [COLOR_W-1:0]  w_s2_red;
    logic [COLOR_W-1:0]  w_s2_green;
    logic [COLOR_W-1:0]  w_s2_blue;

    assign w_clr_last = (r_clr_cnt == ADDR_W'(TOTAL - 1));

    // FSM state register
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state and control outputs: INIT clears RAM, IDLE opens the write port
    always_comb begin
        w_state_nxt = r_state;
        w_init_busy = 1'b0;
        w_wr_ready  = 1'b0;
        w_clr_we    = 1'b0;
        case (r_state)
            ST_INIT: begin
                w_init_busy = 1'b1;
                w_clr_we    = 1'b1;
                if (w_clr_last) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_IDLE: begin
                w_wr_ready = 1'b1;
            end
            default: begin
                w_state_nxt = ST_INIT;
            end
        endcase
    end

    assign init_busy = w_init_busy;
    assign wr_ready  = w_wr_ready;

    // Clear counter walks every entry {bank,index} once; it restarts on reset
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_clr_cnt <= '0;
        end else if (w_clr_we) begin
            r_clr_cnt <= w_clr_last ? '0 : r_clr_cnt + 1'b1;
        end
    end

    // Bank range checks. They reduce to constants when NUM_BANKS is a power of two.
    assign w_wr_bank_ok  = ({1'b0, wr_bank}  < (BANK_W + 1)'(NUM_BANKS));
    assign w_pix_bank_ok = ({1'b0, pix_bank} < (BANK_W + 1)'(NUM_BANKS));

    assign w_wr_addr   = {wr_bank, wr_addr};
    assign w_rd_addr   = {pix_bank, pix_index};
    assign w_usr_we    = w_wr_ready & wr_valid & w_wr_bank_ok;
    assign w_lookup    = pix_valid & (r_state == ST_IDLE);

    // The RAM reads the old value when a read and a write hit the same entry on
    // one edge. The write data is therefore captured as a bypass.
    assign w_byp_hit   = w_usr_we & (w_wr_addr == w_rd_addr);

    assign w_mem_we    = w_clr_we | w_usr_we;
    assign w_mem_addr  = w_clr_we ? r_clr_cnt : w_wr_addr;
    assign w_mem_wdata = w_clr_we ? '0 : wr_data;

    // Palette RAM: single write port, registered read-first read port
    always_ff @(posedge Clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_wdata;
        end
        if (w_lookup) begin
            r_rd_raw <= r_mem[w_rd_addr];
        end
    end

    // Stage 1: sample the request controls along with the RAM read
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_s1_valid    <= 1'b0;
            r_s1_bank_ok  <= 1'b0;
            r_s1_trans    <= 1'b0;
            r_s1_fade     <= '0;
            r_s1_byp_hit  <= 1'b0;
            r_s1_byp_data <= '0;
        end else begin
            r_s1_valid    <= w_lookup;
            r_s1_bank_ok  <= w_pix_bank_ok;
            r_s1_trans    <= trans_en & (pix_index == INDEX_W'(TRANS_IDX));
            r_s1_fade     <= fade;
            r_s1_byp_hit  <= w_byp_hit;
            r_s1_byp_data <= wr_data;
        end
    end

    assign w_s1_entry = r_s1_byp_hit ? r_s1_byp_data : r_rd_raw;

    // Stage 2: resolve the entry. An out-of-range bank reads as black.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_s2_valid <= 1'b0;
            r_s2_trans <= 1'b0;
            r_s2_fade  <= '0;
            r_s2_entry <= '0;
        end else begin
            r_s2_valid <= r_s1_valid;
            r_s2_trans <= r_s1_valid & r_s1_trans;
            r_s2_fade  <= r_s1_fade;
            r_s2_entry <= (r_s1_valid & r_s1_bank_ok) ? w_s1_entry : '0;
        end
    end

    assign w_s2_red   = r_s2_entry[3*COLOR_W-1:2*COLOR_W] >> r_s2_fade;
    assign w_s2_green = r_s2_entry[2*COLOR_W-1:COLOR_W]   >> r_s2_fade;
    assign w_s2_blue  = r_s2_entry[COLOR_W-1:0]           >> r_s2_fade;

    // Output stage: faded colour, or zero when the key matches or no pixel is valid
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            pix_valid_out   <= 1'b0;
            transparent_out <= 1'b0;
            red             <= '0;
            green           <= '0;
            blue            <= '0;
        end else begin
            pix_valid_out   <= r_s2_valid;
            transparent_out <= r_s2_trans;
            if (r_s2_valid && !r_s2_trans) begin
                red   <= w_s2_red;
                green <= w_s2_green;
                blue  <= w_s2_blue;
            end else begin
                red   <= '0;
                green <= '0;
                blue  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_multibank_palette_lut.sv
// Bench for multibank_palette_lut.
// A behavioural palette model is checked against the DUT on every negedge.
// Directed lookups also carry hand-computed literal expectations.
module tb_multibank_palette_lut;

    localparam int INDEX_W   = 8;
    localparam int NUM_BANKS = 2;
    localparam int COLOR_W   = 4;
    localparam int BANK_W    = 1;
    localparam int DEPTH     = 256;
    localparam int TOTAL     = NUM_BANKS * DEPTH;

    // ---------------- clock / reset ----------------
    logic         Clk = 1'b0;
    logic         Reset_n = 1'b0;
    always #5 Clk = ~Clk;

    logic               pix_valid = 1'b0;
    logic [BANK_W-1:0]  pix_bank = '0;
    logic [INDEX_W-1:0] pix_index = '0;
    logic [1:0]         fade = '0;
    logic               trans_en = 1'b0;
    logic               wr_valid = 1'b0;
    logic               wr_ready;
    logic [BANK_W-1:0]  wr_bank = '0;
    logic [INDEX_W-1:0] wr_addr = '0;
    logic [11:0]        wr_data = '0;
    logic               pix_valid_out;
    logic [3:0]         red, green, blue;
    logic               transparent_out;
    logic               init_busy;

    multibank_palette_lut #(
        .INDEX_W(INDEX_W), .NUM_BANKS(NUM_BANKS), .COLOR_W(COLOR_W), .TRANS_IDX(0)
    ) dut (
        .Clk(Clk), .Reset_n(Reset_n),
        .pix_valid(pix_valid), .pix_bank(pix_bank), .pix_index(pix_index),
        .fade(fade), .trans_en(trans_en),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_bank(wr_bank),
        .wr_addr(wr_addr), .wr_data(wr_data),
        .pix_valid_out(pix_valid_out), .red(red), .green(green), .blue(blue),
        .transparent_out(transparent_out), .init_busy(init_busy)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // literal expectations {transparent, r, g, b} for directed lookups
    logic [12:0] exp_q[$];

    // ---------------- behavioural model ----------------
    logic [11:0] m_mem [0:NUM_BANKS-1][0:DEPTH-1];
    int          m_init_left = TOTAL;
    logic        m_s1_v = 1'b0, m_s2_v = 1'b0, m_out_v = 1'b0;
    logic [12:0] m_s1_d = '0, m_s2_d = '0, m_out_d = '0;

    function automatic logic [12:0] model_lookup(int bank, int idx, int fd, bit te);
        logic [11:0] e;
        logic [3:0]  r, g, b;
        if (te && idx == 0) return {1'b1, 12'h000};
        e = (bank < NUM_BANKS) ? m_mem[bank][idx] : 12'h000;
        r = e[11:8] >> fd;
        g = e[7:4]  >> fd;
        b = e[3:0]  >> fd;
        return {1'b0, r, g, b};
    endfunction

    // Model advances on every rising edge. The inputs are stable here.
    initial begin
        forever begin
            @(posedge Clk);
            if (!Reset_n) begin
                for (int b = 0; b < NUM_BANKS; b++)
                    for (int i = 0; i < DEPTH; i++)
                        m_mem[b][i] = 12'h000;
                m_init_left = TOTAL;
                m_s1_v = 0; m_s2_v = 0; m_out_v = 0;
                m_s1_d = 0; m_s2_d = 0; m_out_d = 0;
            end else if (m_init_left > 0) begin
                m_init_left = m_init_left - 1;
                m_out_v = m_s2_v; m_out_d = m_s2_d;
                m_s2_v  = m_s1_v; m_s2_d  = m_s1_d;
                m_s1_v  = 0;      m_s1_d  = 0;
            end else begin
                if (wr_valid && int'(wr_bank) < NUM_BANKS)
                    m_mem[int'(wr_bank)][int'(wr_addr)] = wr_data;
                m_out_v = m_s2_v; m_out_d = m_s2_d;
                m_s2_v  = m_s1_v; m_s2_d  = m_s1_d;
                m_s1_v  = pix_valid;
                m_s1_d  = pix_valid ? model_lookup(int'(pix_bank), int'(pix_index),
                                                   int'(fade), trans_en) : 13'h0;
            end
        end
    end

    // ---------------- scoreboard / compare ----------------
    initial begin
        logic        exp_busy;
        logic [12:0] lit;
        forever begin
            @(negedge Clk);
            if (Reset_n) begin
                exp_busy = (m_init_left > 0);
                n_tests++;
                if (pix_valid_out !== m_out_v ||
                    {transparent_out, red, green, blue} !== m_out_d ||
                    init_busy !== exp_busy || wr_ready !== !exp_busy) begin
                    n_fail++;
                    $display("FAIL model_cycle t=%0t got v=%b trgb=%h busy=%b rdy=%b want v=%b trgb=%h busy=%b rdy=%b",
                             $time, pix_valid_out, {transparent_out, red, green, blue},
                             init_busy, wr_ready, m_out_v, m_out_d, exp_busy, !exp_busy);
                end
                if (pix_valid_out === 1'b1 && exp_q.size() > 0) begin
                    lit = exp_q.pop_front();
                    n_tests++;
                    if ({transparent_out, red, green, blue} !== lit) begin
                        n_fail++;
                        $display("FAIL literal_lookup t=%0t got trgb=%h want trgb=%h",
                                 $time, {transparent_out, red, green, blue}, lit);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input int got, input int want);
        n_tests++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Drive one cycle of inputs, starting and ending on a negedge.
    task automatic step(input bit wv, input int wb, input int wa, input logic [11:0] wd,
                        input bit pv, input int pb, input int pi, input int fd, input bit te);
        wr_valid  = wv;
        wr_bank   = BANK_W'(wb);
        wr_addr   = INDEX_W'(wa);
        wr_data   = wd;
        pix_valid = pv;
        pix_bank  = BANK_W'(pb);
        pix_index = INDEX_W'(pi);
        fade      = 2'(fd);
        trans_en  = te;
        @(negedge Clk);
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 0, 0, 12'h0, 0, 0, 0, 0, 0);
    endtask

    task automatic wr(input int wb, input int wa, input logic [11:0] wd);
        step(1, wb, wa, wd, 0, 0, 0, 0, 0);
    endtask

    task automatic lit_lookup(input int pb, input int pi, input int fd, input bit te,
                              input logic [12:0] want);
        exp_q.push_back(want);
        step(0, 0, 0, 12'h0, 1, pb, pi, fd, te);
    endtask

    // Count negedges with init_busy high. Call this on the negedge where reset is released.
    task automatic wait_init(output int cnt, output bit saw_rdy);
        cnt = 0;
        saw_rdy = 0;
        while (init_busy === 1'b1 && cnt < 2000) begin
            if (wr_ready !== 1'b0) saw_rdy = 1;
            cnt++;
            @(negedge Clk);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int cnt;
        bit saw_rdy;

        repeat (3) @(negedge Clk);
        check("reset_pix_valid_out", int'(pix_valid_out), 0);
        check("reset_rgb", int'({red, green, blue}), 0);
        check("reset_transparent", int'(transparent_out), 0);
        check("reset_init_busy", int'(init_busy), 1);
        check("reset_wr_ready", int'(wr_ready), 0);

        Reset_n = 1'b1;
        wait_init(cnt, saw_rdy);
        check("init_cycles", cnt, 512);
        check("init_wr_ready_low", int'(saw_rdy), 0);

        // cleared entry, then basic writes
        lit_lookup(1, 200, 0, 0, 13'h0000);
        wr(0, 3, 12'hF48);
        wr(1, 3, 12'h0A5);
        wr(0, 0, 12'hFFF);
        // back-to-back lookups across banks
        lit_lookup(0, 3, 0, 0, {1'b0, 12'hF48});
        lit_lookup(1, 3, 0, 0, {1'b0, 12'h0A5});
        // same-edge write and lookup returns new data
        exp_q.push_back({1'b0, 12'hEEB});
        step(1, 0, 7, 12'hEEB, 1, 0, 7, 0, 0);
        // per-request fade
        lit_lookup(0, 3, 2, 0, {1'b0, 12'h312});
        lit_lookup(0, 3, 0, 0, {1'b0, 12'hF48});
        // transparency key
        lit_lookup(0, 0, 0, 1, 13'h1000);
        lit_lookup(0, 0, 0, 0, {1'b0, 12'hFFF});
        idle(4);
        check("literal_queue_drained", exp_q.size(), 0);

        // randomized traffic on a narrow index range to force collisions
        repeat (3000) begin
            int pi;
            pi = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 15);
            step($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 15),
                 12'($urandom), $urandom_range(0, 1), $urandom_range(0, 1), pi,
                 $urandom_range(0, 3), $urandom_range(0, 1));
        end
        idle(4);

        // reset in the middle of INIT: a full clear restarts and earlier writes are lost
        wr(0, 5, 12'h123);
        idle(2);
        Reset_n = 1'b0;
        repeat (2) @(negedge Clk);
        wr_valid = 1; wr_bank = 0; wr_addr = 8'd5; wr_data = 12'hABC;
        pix_valid = 1; pix_bank = 0; pix_index = 8'd5;
        Reset_n = 1'b1;
        repeat (200) @(negedge Clk);
        check("busy_at_cycle_200", int'(init_busy), 1);
        Reset_n = 1'b0;
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;
        wait_init(cnt, saw_rdy);
        idle(1);
        check("reinit_cycles", cnt, 512);
        check("reinit_wr_ready_low", int'(saw_rdy), 0);
        lit_lookup(0, 5, 0, 0, 13'h0000);
        lit_lookup(0, 3, 0, 0, 13'h0000);
        lit_lookup(0, 7, 1, 0, 13'h0000);
        idle(4);
        check("literal_queue_drained_end", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
